// File: rtl/alu_issue_arbiter.sv
// Round-robin issue of reservation-station ops onto the single shared ALU,
// with a one-entry result register handed to the CDB over valid/ready.
package core_pkg;
    typedef enum logic [4:0] {
        ADD_I, SUB_I, AND_I, OR_I, XOR_I, SLL_I, SRL_I, SRA_I,
        SLT_I, SLTU_I, MUL_I, BEQ_I, BNE_I, BLT_I, BGE_I, BLTU_I, BGEU_I
    } instr_opcode;
endpackage

module alu_issue_arbiter
    import core_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 6,
    parameter int MUL_LAT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  instr_opcode              req_opcode [NUM_REQ],
    input  logic [NUM_REQ*32-1:0]    req_val1,
    input  logic [NUM_REQ*32-1:0]    req_val2,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     alu_en,
    output instr_opcode              alu_opcode,
    output logic [31:0]              alu_val1,
    output logic [31:0]              alu_val2,
    input  logic [31:0]              aluout,
    input  logic                     aluout_valid,
    input  logic                     br_cond,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [31:0]              res_data,
    output logic                     res_br_cond,
    output logic [TAG_W-1:0]         res_tag,
    output logic                     err
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [PTR_W:0]   NUM_REQ_W    = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX     = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);

    typedef enum logic [1:0] {IDLE, EXEC, MULW, DONE} state_t;

    state_t           state_reg;
    logic [PTR_W-1:0] rr_ptr_reg;
    logic [CNT_W-1:0] mul_cnt_reg;
    logic             alu_en_reg;
    instr_opcode      op_reg;
    logic [31:0]      val1_reg;
    logic [31:0]      val2_reg;
    logic [TAG_W-1:0] tag_reg;
    logic             res_valid_reg;
    logic [31:0]      res_data_reg;
    logic             res_br_cond_reg;
    logic [TAG_W-1:0] res_tag_reg;
    logic             err_reg;

    logic [PTR_W-1:0] cand_idx [NUM_REQ];
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] rr_ptr_next;
    logic             grant_found;
    logic             grant_window;
    logic             transfer;
    logic             capture;

    // cand_idx[k] is the requester searched k-th, starting at the round-robin pointer
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [PTR_W:0] sum;
            assign sum          = {1'b0, rr_ptr_reg} + (PTR_W+1)'(gi);
            assign cand_idx[gi] = (sum >= NUM_REQ_W) ? PTR_W'(sum - NUM_REQ_W) : sum[PTR_W-1:0];
        end
    endgenerate

    // Scan from the back so the earliest candidate in search order wins
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[cand_idx[k]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
    end

    assign grant_window = ((state_reg == IDLE) || ((state_reg == DONE) && res_ready)) && !flush;
    assign transfer     = grant_window && grant_found;
    assign rr_ptr_next  = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
    assign capture      = (state_reg == EXEC) || ((state_reg == MULW) && (mul_cnt_reg == '0));

    // Gated by rst so no grant is offered while the block is held in reset
    assign req_ready = (rst && transfer) ? (NUM_REQ'(1) << grant_idx) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            rr_ptr_reg      <= '0;
            mul_cnt_reg     <= '0;
            alu_en_reg      <= 1'b0;
            op_reg          <= ADD_I;
            val1_reg        <= '0;
            val2_reg        <= '0;
            tag_reg         <= '0;
            res_valid_reg   <= 1'b0;
            res_data_reg    <= '0;
            res_br_cond_reg <= 1'b0;
            res_tag_reg     <= '0;
            err_reg         <= 1'b0;
        end else if (flush) begin
            state_reg     <= IDLE;
            res_valid_reg <= 1'b0;
            mul_cnt_reg   <= '0;
            alu_en_reg    <= 1'b0;
        end else begin
            if (capture) begin
                res_data_reg    <= aluout;
                res_br_cond_reg <= br_cond;
                res_tag_reg     <= tag_reg;
                res_valid_reg   <= 1'b1;
                alu_en_reg      <= 1'b0;
                state_reg       <= DONE;
                if (!aluout_valid) begin
                    err_reg <= 1'b1;
                end
            end else if (state_reg == MULW) begin
                mul_cnt_reg <= mul_cnt_reg - CNT_W'(1);
            end

            if ((state_reg == DONE) && res_ready) begin
                res_valid_reg <= 1'b0;
                state_reg     <= IDLE;
            end

            // A transfer overrides the IDLE fallback of a same-cycle handshake
            if (transfer) begin
                op_reg     <= req_opcode[grant_idx];
                val1_reg   <= req_val1[32*grant_idx +: 32];
                val2_reg   <= req_val2[32*grant_idx +: 32];
                tag_reg    <= req_tag[TAG_W*grant_idx +: TAG_W];
                rr_ptr_reg <= rr_ptr_next;
                alu_en_reg <= 1'b1;
                if ((req_opcode[grant_idx] == MUL_I) && (MUL_LAT > 1)) begin
                    state_reg   <= MULW;
                    mul_cnt_reg <= MUL_CNT_INIT;
                end else begin
                    state_reg <= EXEC;
                end
            end
        end
    end

    assign alu_en      = alu_en_reg;
    assign alu_opcode  = op_reg;
    assign alu_val1    = val1_reg;
    assign alu_val2    = val2_reg;
    assign res_valid   = res_valid_reg;
    assign res_data    = res_data_reg;
    assign res_br_cond = res_br_cond_reg;
    assign res_tag     = res_tag_reg;
    assign err         = err_reg;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: directed scenarios plus a randomized op stream
// checked against a transaction-level model of grant order, latency and results.
module tb_alu_issue_arbiter;
    import core_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int TAG_W   = 6;
    localparam int MUL_LAT = 3;
    localparam int OPS_PER = 8;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     flush = 1'b0;
    logic [NUM_REQ-1:0]       req_valid = '0;
    instr_opcode              req_opcode [NUM_REQ];
    logic [NUM_REQ*32-1:0]    req_val1 = '0;
    logic [NUM_REQ*32-1:0]    req_val2 = '0;
    logic [NUM_REQ*TAG_W-1:0] req_tag = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     alu_en;
    instr_opcode              alu_opcode;
    logic [31:0]              alu_val1;
    logic [31:0]              alu_val2;
    logic [31:0]              aluout;
    logic                     aluout_valid = 1'b1;
    logic                     br_cond;
    logic                     res_valid;
    logic                     res_ready = 1'b0;
    logic [31:0]              res_data;
    logic                     res_br_cond;
    logic [TAG_W-1:0]         res_tag;
    logic                     err;

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        instr_opcode      op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
    } op_t;

    alu_issue_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_opcode(req_opcode), .req_val1(req_val1),
        .req_val2(req_val2), .req_tag(req_tag), .req_ready(req_ready),
        .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_val1(alu_val1), .alu_val2(alu_val2),
        .aluout(aluout), .aluout_valid(aluout_valid), .br_cond(br_cond),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_br_cond(res_br_cond), .res_tag(res_tag), .err(err)
    );

    always #5 clk = ~clk;

    // Architectural ALU behaviour: returns {br_cond, result}
    function automatic logic [32:0] alu_ref(input instr_opcode op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        logic        br;
        d  = '0;
        br = 1'b0;
        case (op)
            ADD_I:  d = a + b;
            SUB_I:  d = a - b;
            AND_I:  d = a & b;
            OR_I:   d = a | b;
            XOR_I:  d = a ^ b;
            SLL_I:  d = a << b[4:0];
            SRL_I:  d = a >> b[4:0];
            SRA_I:  d = $signed(a) >>> b[4:0];
            SLT_I:  d = {31'b0, $signed(a) < $signed(b)};
            SLTU_I: d = {31'b0, a < b};
            MUL_I:  d = a * b;
            BEQ_I:  begin d = a - b; br = (a == b); end
            BNE_I:  begin d = a - b; br = (a != b); end
            BLT_I:  begin d = a - b; br = ($signed(a) < $signed(b)); end
            BGE_I:  begin d = a - b; br = ($signed(a) >= $signed(b)); end
            BLTU_I: begin d = a - b; br = (a < b); end
            BGEU_I: begin d = a - b; br = (a >= b); end
            default: ;
        endcase
        return {br, d};
    endfunction

    always_comb {br_cond, aluout} = alu_ref(alu_opcode, alu_val1, alu_val2);

    task automatic set_req(input int i, input instr_opcode op, input logic [31:0] a,
                           input logic [31:0] b, input logic [TAG_W-1:0] t);
        req_opcode[i]             = op;
        req_val1[32*i +: 32]      = a;
        req_val2[32*i +: 32]      = b;
        req_tag[TAG_W*i +: TAG_W] = t;
    endtask

    task automatic do_reset();
        rst = 1'b0; flush = 1'b0; req_valid = '0; res_ready = 1'b0; aluout_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Single op from requester i through to handshake; ok=0 on any timeout
    task automatic issue_op(input int i, input instr_opcode op, input logic [31:0] a, input logic [31:0] b,
                            input logic [TAG_W-1:0] t, output logic [31:0] d, output logic br,
                            output logic [TAG_W-1:0] tg, output bit ok);
        ok = 1'b0; d = '0; br = 1'b0; tg = '0;
        @(negedge clk);
        set_req(i, op, a, b, t);
        req_valid = NUM_REQ'(1) << i;
        #1;
        for (int w = 0; w < 10 && req_ready == '0; w++) begin @(negedge clk); #1; end
        if (req_ready == '0) begin req_valid = '0; return; end
        @(negedge clk);
        req_valid = '0;
        for (int w = 0; w < 20 && !res_valid; w++) @(negedge clk);
        if (!res_valid) return;
        d = res_data; br = res_br_cond; tg = res_tag; ok = 1'b1;
        $display("txn: req%0d op=%s a=%h b=%h -> data=%h br=%b tag=%0d", i, op.name(), a, b, d, br, tg);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = '1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, ADD_I, 32'd1, 32'd1, TAG_W'(i));
        @(negedge clk); #1;
        checks++; if (req_ready !== '0)   begin fails++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        checks++; if (alu_en !== 1'b0)    begin fails++; $display("FAIL reset_alu_en: got %b want 0", alu_en); end
        checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        checks++; if (err !== 1'b0)       begin fails++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (res_data !== 32'd0 || res_tag !== '0 || res_br_cond !== 1'b0)
            begin fails++; $display("FAIL reset_res_regs: got %h/%0d/%b want 0/0/0", res_data, res_tag, res_br_cond); end
        checks++; if (alu_val1 !== 32'd0 || alu_val2 !== 32'd0 || alu_opcode !== ADD_I)
            begin fails++; $display("FAIL reset_alu_regs: got %h/%h/%0d want 0/0/0", alu_val1, alu_val2, alu_opcode); end
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single_add();
        do_reset();
        @(negedge clk);
        set_req(0, ADD_I, 32'd5, 32'd7, 6'd3);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL add_grant: got %b want 0001", req_ready); end
        @(negedge clk); req_valid = '0; #1;
        checks++; if (alu_en !== 1'b1 || alu_opcode !== ADD_I || alu_val1 !== 32'd5 || alu_val2 !== 32'd7)
            begin fails++; $display("FAIL add_exec: got en=%b op=%0d %h %h want 1 ADD 5 7", alu_en, alu_opcode, alu_val1, alu_val2); end
        checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL add_early_valid: got %b want 0", res_valid); end
        @(negedge clk); #1;
        checks++; if (res_valid !== 1'b1 || res_data !== 32'd12 || res_tag !== 6'd3 || alu_en !== 1'b0)
            begin fails++; $display("FAIL add_result: got v=%b d=%0d tag=%0d en=%b want 1 12 3 0", res_valid, res_data, res_tag, alu_en); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            checks++; if (res_valid !== 1'b1 || res_data !== 32'd12)
                begin fails++; $display("FAIL add_hold: got v=%b d=%0d want 1 12", res_valid, res_data); end
        end
        $display("txn: req0 ADD 5+7 -> data=%0d tag=%0d", res_data, res_tag);
        res_ready = 1'b1;
        @(negedge clk); res_ready = 1'b0; #1;
        checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL add_release: got %b want 0", res_valid); end
    endtask

    task automatic test_all_valid();
        do_reset();
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) set_req(i, ADD_I, 32'(10 * i), 32'(i), TAG_W'(10 + i));
        req_valid = '1; res_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            logic [NUM_REQ-1:0] exp_rdy;
            if (k > 0) @(negedge clk);
            #1;
            exp_rdy = (k % 2 == 0) ? (NUM_REQ'(1) << ((k / 2) % NUM_REQ)) : '0;
            checks++; if (req_ready !== exp_rdy) begin fails++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp_rdy); end
            if (k >= 2) begin
                checks++; if (res_valid !== (k % 2 == 0)) begin fails++; $display("FAIL rr_valid[%0d]: got %b want %b", k, res_valid, k % 2 == 0); end
                if (k % 2 == 0) begin
                    checks++; if (res_tag !== TAG_W'(10 + ((k / 2 - 1) % NUM_REQ)))
                        begin fails++; $display("FAIL rr_tag[%0d]: got %0d want %0d", k, res_tag, 10 + ((k / 2 - 1) % NUM_REQ)); end
                    $display("txn: stream result tag=%0d data=%0d", res_tag, res_data);
                end
            end
        end
        req_valid = '0;
        repeat (3) @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_mul();
        int en_cnt;
        do_reset();
        @(negedge clk);
        set_req(0, MUL_I, -32'sd3, 32'd4, 6'd5);
        req_valid = 4'b0001; #1;
        checks++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL mul_grant: got %b want 0001", req_ready); end
        en_cnt = 0;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk); req_valid = '0; #1;
            if (alu_en) en_cnt++;
            if (j == MUL_LAT) begin
                checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL mul_early: got %b want 0", res_valid); end
            end
            if (j == MUL_LAT + 1) begin
                checks++; if (res_valid !== 1'b1 || res_data !== 32'hFFFF_FFF4 || res_tag !== 6'd5)
                    begin fails++; $display("FAIL mul_result: got v=%b d=%h tag=%0d want 1 fffffff4 5", res_valid, res_data, res_tag); end
                $display("txn: req0 MUL -3*4 -> data=%h", res_data);
            end
        end
        checks++; if (en_cnt != MUL_LAT) begin fails++; $display("FAIL mul_en_cycles: got %0d want %0d", en_cnt, MUL_LAT); end
        res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    endtask

    task automatic test_branch();
        logic [31:0] d; logic br; logic [TAG_W-1:0] tg; bit ok;
        do_reset();
        issue_op(1, BLT_I, 32'hFFFF_FFFF, 32'd1, 6'd7, d, br, tg, ok);
        checks++; if (!ok || br !== 1'b1 || tg !== 6'd7) begin fails++; $display("FAIL blt: got ok=%b br=%b tag=%0d want 1 1 7", ok, br, tg); end
        issue_op(2, BLTU_I, 32'hFFFF_FFFF, 32'd1, 6'd8, d, br, tg, ok);
        checks++; if (!ok || br !== 1'b0 || tg !== 6'd8) begin fails++; $display("FAIL bltu: got ok=%b br=%b tag=%0d want 1 0 8", ok, br, tg); end
        issue_op(3, BEQ_I, 32'd4, 32'd4, 6'd9, d, br, tg, ok);
        checks++; if (!ok || br !== 1'b1 || d !== 32'd0) begin fails++; $display("FAIL beq: got ok=%b br=%b d=%h want 1 1 0", ok, br, d); end
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk);
        set_req(0, ADD_I, 32'd1, 32'd2, 6'd20);
        req_valid = 4'b0001; #1;
        checks++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL bp_first_grant: got %b want 0001", req_ready); end
        @(negedge clk);
        set_req(1, SUB_I, 32'd9, 32'd4, 6'd21);
        set_req(2, XOR_I, 32'd3, 32'd6, 6'd22);
        req_valid = 4'b0110; #1;
        checks++; if (req_ready !== '0) begin fails++; $display("FAIL bp_exec_ready: got %b want 0", req_ready); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            checks++; if (req_ready !== '0 || res_valid !== 1'b1 || res_data !== 32'd3 || res_tag !== 6'd20)
                begin fails++; $display("FAIL bp_hold[%0d]: got rdy=%b v=%b d=%0d tag=%0d want 0 1 3 20", c, req_ready, res_valid, res_data, res_tag); end
        end
        res_ready = 1'b1; #1;
        checks++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL bp_same_cycle_grant: got %b want 0010", req_ready); end
        @(negedge clk); res_ready = 1'b0; req_valid = '0; #1;
        checks++; if (alu_en !== 1'b1 || alu_val1 !== 32'd9 || res_valid !== 1'b0)
            begin fails++; $display("FAIL bp_next_exec: got en=%b a=%0d v=%b want 1 9 0", alu_en, alu_val1, res_valid); end
        @(negedge clk); #1;
        checks++; if (res_valid !== 1'b1 || res_data !== 32'd5 || res_tag !== 6'd21)
            begin fails++; $display("FAIL bp_next_result: got v=%b d=%0d tag=%0d want 1 5 21", res_valid, res_data, res_tag); end
        $display("txn: req1 SUB 9-4 -> data=%0d tag=%0d", res_data, res_tag);
        res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic [31:0] d; logic br; logic [TAG_W-1:0] tg; bit ok; bit seen;
        do_reset();
        issue_op(1, ADD_I, 32'd2, 32'd2, 6'd31, d, br, tg, ok);
        checks++; if (!ok || d !== 32'd4) begin fails++; $display("FAIL flush_pre_op: got ok=%b d=%0d want 1 4", ok, d); end
        @(negedge clk);
        set_req(2, MUL_I, 32'd6, 32'd7, 6'd30);
        req_valid = 4'b0100; #1;
        checks++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL flush_mul_grant: got %b want 0100", req_ready); end
        @(negedge clk); req_valid = '0; #1;
        checks++; if (alu_en !== 1'b1) begin fails++; $display("FAIL flush_mulw_en: got %b want 1", alu_en); end
        flush = 1'b1;
        @(negedge clk); flush = 1'b0; #1;
        checks++; if (alu_en !== 1'b0 || res_valid !== 1'b0 || err !== 1'b0)
            begin fails++; $display("FAIL flush_kill: got en=%b v=%b err=%b want 0 0 0", alu_en, res_valid, err); end
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin @(negedge clk); if (res_valid) seen = 1'b1; end
        checks++; if (seen) begin fails++; $display("FAIL flush_no_result: got res_valid=1 want 0"); end
        for (int i = 0; i < NUM_REQ; i++) set_req(i, ADD_I, 32'(i), 32'd100, TAG_W'(40 + i));
        req_valid = '1; #1;
        checks++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL flush_rr_kept: got %b want 1000", req_ready); end
        @(negedge clk); req_valid = '0;
        for (int w = 0; w < 10 && !res_valid; w++) @(negedge clk);
        checks++; if (res_valid !== 1'b1 || res_tag !== 6'd43 || res_data !== 32'd103)
            begin fails++; $display("FAIL flush_after_grant: got v=%b tag=%0d d=%0d want 1 43 103", res_valid, res_tag, res_data); end
        res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [31:0] d; logic br; logic [TAG_W-1:0] tg; bit ok;
        do_reset();
        issue_op(0, OR_I, 32'hA0, 32'h0B, 6'd12, d, br, tg, ok);
        @(negedge clk);
        set_req(1, ADD_I, 32'd5, 32'd7, 6'd3);
        req_valid = 4'b0010;
        @(negedge clk); req_valid = '1; #1;
        checks++; if (alu_en !== 1'b1) begin fails++; $display("FAIL arst_in_exec: got %b want 1", alu_en); end
        rst = 1'b0; #1;
        checks++; if (alu_en !== 1'b0 || res_valid !== 1'b0 || req_ready !== '0)
            begin fails++; $display("FAIL arst_ctrl: got en=%b v=%b rdy=%b want 0 0 0", alu_en, res_valid, req_ready); end
        checks++; if (res_data !== 32'd0 || res_tag !== '0 || alu_val1 !== 32'd0 || alu_opcode !== ADD_I)
            begin fails++; $display("FAIL arst_data: got d=%h tag=%0d a=%h op=%0d want 0 0 0 0", res_data, res_tag, alu_val1, alu_opcode); end
        req_valid = '0;
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_err();
        logic [31:0] d; logic br; logic [TAG_W-1:0] tg; bit ok;
        do_reset();
        aluout_valid = 1'b0;
        issue_op(0, ADD_I, 32'd1, 32'd1, 6'd1, d, br, tg, ok);
        aluout_valid = 1'b1;
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL err_set: got %b want 1", err); end
        issue_op(1, ADD_I, 32'd2, 32'd3, 6'd2, d, br, tg, ok);
        checks++; if (err !== 1'b1 || !ok || d !== 32'd5) begin fails++; $display("FAIL err_sticky: got err=%b d=%0d want 1 5", err, d); end
        do_reset();
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL err_cleared: got %b want 0", err); end
    endtask

    // Randomized stream: model tracks the rr pointer, one op in flight and one held result
    task automatic test_random();
        op_t         ops [NUM_REQ][OPS_PER];
        int          head [NUM_REQ];
        instr_opcode pick [9];
        int          ptr, due, remaining, results, n, g;
        bit          inflight, pending;
        logic [32:0] r;
        logic [31:0] exp_d, exp_a;
        logic        exp_br;
        logic [TAG_W-1:0] exp_t;
        instr_opcode exp_op;
        logic [NUM_REQ-1:0] exp_rdy;
        pick = '{ADD_I, SUB_I, XOR_I, SLT_I, SLTU_I, MUL_I, BLT_I, BLTU_I, BEQ_I};
        for (int i = 0; i < NUM_REQ; i++) begin
            head[i] = 0;
            for (int j = 0; j < OPS_PER; j++) begin
                ops[i][j].op  = pick[$urandom_range(0, 8)];
                ops[i][j].a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
                ops[i][j].b   = ($urandom_range(0, 3) == 0) ? ops[i][j].a : $urandom;
                ops[i][j].tag = TAG_W'(i * OPS_PER + j);
            end
        end
        do_reset();
        ptr = 0; due = 0; inflight = 0; pending = 0; results = 0;
        remaining = NUM_REQ * OPS_PER;
        exp_d = '0; exp_br = 1'b0; exp_t = '0; exp_a = '0; exp_op = ADD_I;
        for (n = 0; n < 3000 && (remaining > 0 || inflight || pending); n++) begin
            @(negedge clk);
            if (inflight && n == due) begin inflight = 0; pending = 1; end
            checks++; if (res_valid !== pending) begin fails++; $display("FAIL rnd_valid@%0d: got %b want %b", n, res_valid, pending); end
            checks++; if (alu_en !== inflight) begin fails++; $display("FAIL rnd_alu_en@%0d: got %b want %b", n, alu_en, inflight); end
            if (inflight) begin
                checks++; if (alu_opcode !== exp_op || alu_val1 !== exp_a)
                    begin fails++; $display("FAIL rnd_alu_ops@%0d: got %0d %h want %0d %h", n, alu_opcode, alu_val1, exp_op, exp_a); end
            end
            if (pending) begin
                checks++; if (res_data !== exp_d || res_br_cond !== exp_br || res_tag !== exp_t)
                    begin fails++; $display("FAIL rnd_result@%0d: got %h/%b/%0d want %h/%b/%0d", n, res_data, res_br_cond, res_tag, exp_d, exp_br, exp_t); end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                req_valid[i] = (head[i] < OPS_PER) && ($urandom_range(0, 3) != 0);
                if (head[i] < OPS_PER)
                    set_req(i, ops[i][head[i]].op, ops[i][head[i]].a, ops[i][head[i]].b, ops[i][head[i]].tag);
            end
            res_ready = ($urandom_range(0, 2) != 0);
            #1;
            g = -1;
            if (!inflight && (!pending || res_ready)) begin
                for (int k = NUM_REQ - 1; k >= 0; k--)
                    if (req_valid[(ptr + k) % NUM_REQ]) g = (ptr + k) % NUM_REQ;
            end
            exp_rdy = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
            checks++; if (req_ready !== exp_rdy) begin fails++; $display("FAIL rnd_grant@%0d: got %b want %b", n, req_ready, exp_rdy); end
            if (pending && res_ready) begin
                pending = 0; results++;
                $display("txn: result tag=%0d data=%h br=%b", exp_t, exp_d, exp_br);
            end
            if (g >= 0) begin
                r = alu_ref(ops[g][head[g]].op, ops[g][head[g]].a, ops[g][head[g]].b);
                exp_d = r[31:0]; exp_br = r[32]; exp_t = ops[g][head[g]].tag;
                exp_a = ops[g][head[g]].a; exp_op = ops[g][head[g]].op;
                due = n + ((exp_op == MUL_I) ? 1 + MUL_LAT : 2);
                inflight = 1; ptr = (g + 1) % NUM_REQ;
                head[g]++; remaining--;
            end
        end
        req_valid = '0; res_ready = 1'b0;
        checks++; if (results != NUM_REQ * OPS_PER) begin fails++; $display("FAIL rnd_count: got %0d want %0d results", results, NUM_REQ * OPS_PER); end
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) req_opcode[i] = ADD_I;
        test_reset();
        test_single_add();
        test_all_valid();
        test_mul();
        test_branch();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_err();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
